pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits and HLT drain. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It resolves these hazards:
//   - data-memory waits
//   - taken-branch flushes
//   - load-use bubbles
//   - HLT drain
// It also keeps a saturating stall-cycle counter for perf debug.
// Outputs are Mealy: they decode from the current state and this cycle's inputs.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       IFID_RegRs,
  input  logic [3:0]       IFID_RegRt,
  input  logic             id_uses_rt,
  input  logic             id_hlt,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_RegRd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          luh, mw;

  assign luh = IDEX_MemRead && (IDEX_RegRd != 4'd0) &&
               ((IDEX_RegRd == IFID_RegRs) || (id_uses_rt && (IDEX_RegRd == IFID_RegRt)));
  assign mw  = mem_req && !mem_ready;

  // Next-state and enable/flush decode. The RUN rules (minus mw) are shared by
  // RUN and by the MEM_WAIT exit cycle. In that exit cycle, the frozen pipeline
  // still presents the branch, luh and HLT inputs.
  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if ((state == RUN) ? mw : !mem_ready) begin
          state_nxt = MEM_WAIT;
        end else begin
          state_nxt = RUN;
          idex_en   = 1'b1;
          exmem_en  = 1'b1;
          memwb_en  = 1'b1;
          if (ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (luh) begin
            idex_flush = 1'b1;
          end else if (id_hlt) begin
            drain_nxt = DW'(DRAIN_CYCLES);
            state_nxt = DRAIN;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!mw) begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (ex_branch_taken) begin
            // An older branch ahead of the HLT squashes it.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
          end else begin
            idex_flush = 1'b1;
            drain_nxt  = drain_cnt - 1'b1;
            if (drain_cnt == DW'(1)) state_nxt = HALTED;
          end
        end
      end
      HALTED:  halted = 1'b1;
      default: state_nxt = RUN;
    endcase
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      halted     = 1'b0;
    end
  end

  // State and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Saturating count of stalled (pc_en=0) cycles, excluding HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (!pc_en && (state != HALTED) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
